id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width of PC, operands and immediate.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 id_valid  in  1  decode stage holds a real instruction.
REQ-005 id_alu_op  in  2  ALUOp from main control (00 add, 01 branch-compare, 10 funct-decoded).
REQ-006 id_mem_read, id_mem_write, id_reg_write, id_branch, id_alu_src, id_mem_to_reg  in  1 each  main-control flags.
REQ-007 id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decode-stage PC, register-file reads, sign-extended immediate.
REQ-008 id_rs1, id_rs2, id_rd  in  5 each  register indices; id_funct3  in  3; id_funct7_5  in  1.
REQ-009 ex_flush  in  1  branch/jump redirect from EX; kills the instruction in decode.
REQ-010 ex_valid  out  1  registered instruction in EX is real.
REQ-011 ex_alu_op  out  2; ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_alu_src, ex_mem_to_reg  out  1 each  registered control.
REQ-012 ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN; ex_rs1, ex_rs2, ex_rd  out  5; ex_funct3  out  3; ex_funct7_5  out  1  registered payload.
REQ-013 stall  out  1  combinational load-use hazard; upstream PC and IF/ID register hold while high.
REQ-014 stall_count  out  16  registered count of bubble cycles caused by stall.

Function
REQ-015 Hazard: stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2) & ~ex_flush.
REQ-016 Bubble condition = ex_flush | stall | ~id_valid.
REQ-017 Each cycle without bubble: all ex_* outputs load the corresponding id_* inputs; ex_valid <= 1; latency exactly one cycle.
REQ-018 Each bubble cycle: ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch <= 0; ex_alu_op <= 00; ex_alu_src, ex_mem_to_reg <= 0.
REQ-019 On bubble, payload (ex_pc, data, imm, indices, funct) may hold or load; verification checks payload only when ex_valid = 1.
REQ-020 ex_flush has priority over stall: flush cycle inserts bubble, stall output forced 0, stall_count unchanged.
REQ-021 Stall lasts exactly one cycle per load-use pair: after bubble, ex_mem_read = 0, so stall drops and the held instruction advances next cycle.
REQ-022 rd = x0 never causes stall, even if the load targets x0 and rs1/rs2 = 0.
REQ-023 stall_count increments by 1 on each rising edge with stall = 1; saturates at 16'hFFFF (no wrap).
REQ-024 Store after load (rs2 match) stalls identically to ALU use; no forwarding-aware exemption.
REQ-025 No internal state beyond the pipeline register and stall_count; no FSM beyond valid bit.

Reset
REQ-026 When rst_n = 0 at a rising edge: ex_valid and all control outputs <= 0, ex_alu_op <= 00, payload outputs <= 0, stall_count <= 0.
REQ-027 Reset overrides flush, stall and id_valid in the same cycle.
REQ-028 stall is 0 in the first cycle after reset (ex_valid = 0).
REQ-029 Reset asserted mid-stall discards both the EX-stage load and the held decode instruction from EX; upstream refetch is upstream's responsibility.

Verification
REQ-030 Straight-line: add x3,x1,x2 (alu_op 10, reg_write 1) then addi x4,x3,5 (alu_src 1, imm 5) -> each appears on ex_* one cycle later, ex_valid 1, stall never 1.
REQ-031 Load-use: lw x5,0(x1) then add x6,x5,x2 -> stall = 1 for one cycle, ex_valid = 0 that next cycle, add enters EX the cycle after, stall_count = 1.
REQ-032 Load to x0: lw x0,0(x1) then add x6,x0,x0 -> no stall, stall_count stays 0.
REQ-033 Flush vs stall: load in EX, dependent add in ID, ex_flush = 1 same cycle -> stall = 0, bubble inserted, stall_count unchanged.
REQ-034 Saturation: force 70000 load-use pairs -> stall_count reads 16'hFFFF and holds.
REQ-035 Reset mid-stream: rst_n = 0 with valid sw in ID and lw in EX -> next cycle ex_valid 0, ex_mem_write 0, all payload 0, stall_count 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// A stall or flush turns the EX slot into a bubble; payload fields simply hold on bubbles.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [1:0]      id_alu_op,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            id_branch,
    input  logic            id_alu_src,
    input  logic            id_mem_to_reg,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic            ex_flush,
    output logic            ex_valid,
    output logic [1:0]      ex_alu_op,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_alu_src,
    output logic            ex_mem_to_reg,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7_5,
    output logic            stall,
    output logic [CNT_W-1:0] stall_count
);

    logic             w_stall;
    logic             w_bubble;
    logic [CNT_W-1:0] r_stall_count;

    // Flush kills the decode instruction, so it also masks the hazard.
    always_comb begin
        w_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0)
                & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~ex_flush;
        w_bubble = ex_flush | w_stall | ~id_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_pc         <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_funct3     <= '0;
            ex_funct7_5   <= 1'b0;
        end else if (w_bubble) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else begin
            ex_valid      <= 1'b1;
            ex_alu_op     <= id_alu_op;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_reg_write  <= id_reg_write;
            ex_branch     <= id_branch;
            ex_alu_src    <= id_alu_src;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_pc         <= id_pc;
            ex_rs1_data   <= id_rs1_data;
            ex_rs2_data   <= id_rs2_data;
            ex_imm        <= id_imm;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
            ex_funct3     <= id_funct3;
            ex_funct7_5   <= id_funct7_5;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall       = w_stall;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with a 4-bit counter exercises saturation quickly.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [1:0]  alu_op;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        alu_src;
        logic        mem_to_reg;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7_5;
    } instr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ex_flush;
    instr_t id;

    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_alu_src, ex_mem_to_reg;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_5, stall;
    logic [15:0] stall_count;

    logic        s_valid, s_mem_read, s_mem_write, s_reg_write, s_branch, s_alu_src, s_mem_to_reg;
    logic [1:0]  s_alu_op;
    logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [2:0]  s_funct3;
    logic        s_funct7_5, s_stall;
    logic [3:0]  s_stall_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id.valid), .id_alu_op(id.alu_op),
        .id_mem_read(id.mem_read), .id_mem_write(id.mem_write), .id_reg_write(id.reg_write),
        .id_branch(id.branch), .id_alu_src(id.alu_src), .id_mem_to_reg(id.mem_to_reg),
        .id_pc(id.pc), .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data), .id_imm(id.imm),
        .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd), .id_funct3(id.funct3),
        .id_funct7_5(id.funct7_5), .ex_flush(ex_flush),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
        .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7_5(ex_funct7_5), .stall(stall), .stall_count(stall_count)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id.valid), .id_alu_op(id.alu_op),
        .id_mem_read(id.mem_read), .id_mem_write(id.mem_write), .id_reg_write(id.reg_write),
        .id_branch(id.branch), .id_alu_src(id.alu_src), .id_mem_to_reg(id.mem_to_reg),
        .id_pc(id.pc), .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data), .id_imm(id.imm),
        .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd), .id_funct3(id.funct3),
        .id_funct7_5(id.funct7_5), .ex_flush(ex_flush),
        .ex_valid(s_valid), .ex_alu_op(s_alu_op), .ex_mem_read(s_mem_read),
        .ex_mem_write(s_mem_write), .ex_reg_write(s_reg_write), .ex_branch(s_branch),
        .ex_alu_src(s_alu_src), .ex_mem_to_reg(s_mem_to_reg), .ex_pc(s_pc),
        .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
        .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct3(s_funct3),
        .ex_funct7_5(s_funct7_5), .stall(s_stall), .stall_count(s_stall_count)
    );

    function automatic instr_t base(input logic [31:0] pc, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t t = '0;
        t.valid    = 1'b1;
        t.pc       = pc;
        t.rd       = rd;
        t.rs1      = rs1;
        t.rs2      = rs2;
        t.rs1_data = 32'h1000_0000 | 32'(rs1);
        t.rs2_data = 32'h2000_0000 | 32'(rs2);
        return t;
    endfunction

    function automatic instr_t op_add(input logic [31:0] pc, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t t = base(pc, rd, rs1, rs2);
        t.alu_op    = 2'b10;
        t.reg_write = 1'b1;
        return t;
    endfunction

    function automatic instr_t op_addi(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [31:0] imm);
        instr_t t = base(pc, rd, rs1, 5'd5);
        t.alu_src   = 1'b1;
        t.reg_write = 1'b1;
        t.imm       = imm;
        return t;
    endfunction

    function automatic instr_t op_lw(input logic [31:0] pc, input logic [4:0] rd,
                                     input logic [4:0] rs1);
        instr_t t = base(pc, rd, rs1, 5'd0);
        t.mem_read   = 1'b1;
        t.reg_write  = 1'b1;
        t.alu_src    = 1'b1;
        t.mem_to_reg = 1'b1;
        t.funct3     = 3'b010;
        return t;
    endfunction

    function automatic instr_t op_sw(input logic [31:0] pc, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
        instr_t t = base(pc, 5'd0, rs1, rs2);
        t.mem_write = 1'b1;
        t.alu_src   = 1'b1;
        t.funct3    = 3'b010;
        t.imm       = 32'd8;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input instr_t exp);
        instr_t obs;
        obs = {ex_valid, ex_alu_op, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch,
               ex_alu_src, ex_mem_to_reg, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_5};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Only ex_valid and the control fields are defined while the slot is a bubble.
    task automatic chk_bubble(input string tag);
        chk(tag, 32'({ex_valid, ex_alu_op, ex_mem_read, ex_mem_write, ex_reg_write,
                      ex_branch, ex_alu_src, ex_mem_to_reg}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t a, b;

        // Reset wins over a valid instruction and a flush in the same cycle.
        rst_n    = 1'b0;
        ex_flush = 1'b1;
        id       = op_lw(32'h80, 5'd9, 5'd1);
        tick();
        tick();
        chk_ex("reset_all_zero", '0);
        chk("reset_count", 32'(stall_count), 32'd0);
        rst_n    = 1'b1;
        ex_flush = 1'b0;
        id       = '0;
        settle();
        chk("post_reset_stall", 32'(stall), 32'd0);
        tick();

        // Straight-line add then dependent addi: no load, no stall.
        a = op_add(32'h100, 5'd3, 5'd1, 5'd2);
        id = a;
        settle();
        chk("add_no_stall", 32'(stall), 32'd0);
        tick();
        chk_ex("add_in_ex", a);
        b = op_addi(32'h104, 5'd4, 5'd3, 32'd5);
        id = b;
        settle();
        chk("addi_no_stall", 32'(stall), 32'd0);
        tick();
        chk_ex("addi_in_ex", b);

        // Load-use: one bubble, then the held add advances.
        a = op_lw(32'h108, 5'd5, 5'd1);
        id = a;
        tick();
        chk_ex("lw_in_ex", a);
        b = op_add(32'h10c, 5'd6, 5'd5, 5'd2);
        id = b;
        settle();
        chk("loaduse_stall", 32'(stall), 32'd1);
        tick();
        chk_bubble("loaduse_bubble");
        chk("loaduse_count", 32'(stall_count), 32'd1);
        chk("loaduse_stall_drop", 32'(stall), 32'd0);
        tick();
        chk_ex("loaduse_add_in_ex", b);
        chk("loaduse_count_hold", 32'(stall_count), 32'd1);

        // Load to x0 never stalls.
        a = op_lw(32'h110, 5'd0, 5'd1);
        id = a;
        tick();
        b = op_add(32'h114, 5'd6, 5'd0, 5'd0);
        id = b;
        settle();
        chk("x0_no_stall", 32'(stall), 32'd0);
        tick();
        chk_ex("x0_add_in_ex", b);
        chk("x0_count", 32'(stall_count), 32'd1);

        // Store consuming the load through rs2 stalls the same way.
        a = op_lw(32'h118, 5'd7, 5'd1);
        id = a;
        tick();
        b = op_sw(32'h11c, 5'd1, 5'd7);
        id = b;
        settle();
        chk("sw_rs2_stall", 32'(stall), 32'd1);
        tick();
        chk_bubble("sw_bubble");
        chk("sw_count", 32'(stall_count), 32'd2);
        tick();
        chk_ex("sw_in_ex", b);

        // Flush beats stall: stall masked, bubble inserted, count unchanged.
        a = op_lw(32'h120, 5'd8, 5'd1);
        id = a;
        tick();
        id = op_add(32'h124, 5'd9, 5'd8, 5'd8);
        ex_flush = 1'b1;
        settle();
        chk("flush_masks_stall", 32'(stall), 32'd0);
        tick();
        chk_bubble("flush_bubble");
        chk("flush_count", 32'(stall_count), 32'd2);
        ex_flush = 1'b0;

        // Invalid decode slot becomes a bubble even with control bits set.
        a = op_add(32'h128, 5'd10, 5'd1, 5'd2);
        a.valid = 1'b0;
        id = a;
        tick();
        chk_bubble("invalid_bubble");

        // Repeated load-use pairs: 4-bit instance saturates at 15, 16-bit keeps counting.
        for (int i = 0; i < 20; i++) begin
            id = op_lw(32'h200 + 32'(i * 8), 5'd5, 5'd1);
            tick();
            id = op_add(32'h204 + 32'(i * 8), 5'd6, 5'd2, 5'd5);
            tick();
            tick();
            if (i == 11) begin
                chk("sat_below_max", 32'(s_stall_count), 32'd14);
                chk("main_at_14", 32'(stall_count), 32'd14);
            end
            if (i == 12) chk("sat_reaches_max", 32'(s_stall_count), 32'd15);
        end
        chk("sat_holds_max", 32'(s_stall_count), 32'd15);
        chk("main_count_22", 32'(stall_count), 32'd22);

        // Reset during a stall: lw in EX, dependent sw held in decode.
        a = op_lw(32'h300, 5'd10, 5'd1);
        id = a;
        tick();
        id = op_sw(32'h304, 5'd1, 5'd10);
        settle();
        chk("pre_reset_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_ex("midreset_all_zero", '0);
        chk("midreset_count", 32'(stall_count), 32'd0);
        chk("midreset_sat_count", 32'(s_stall_count), 32'd0);
        rst_n = 1'b1;
        settle();
        chk("after_reset_no_stall", 32'(stall), 32'd0);
        b = id;
        tick();
        chk_ex("after_reset_sw_in_ex", b);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
